uart_tx_arbiter: RTL and testbench

Shares the single housekeeping UART transmitter between two byte-stream requesters: the housekeeping CPU's reply path (requester 0) and an autonomous status/telemetry beacon (requester 1). Arbitration is message-granular: once a requester is granted, only its bytes reach the UART until it presents a byte flagged `last`, or until it stalls past a timeout. The block sits between the requesters and the `uart_tx` instance and uses the shared 16x baud tick for its timeout.

---
 rtl/uart_tx_arbiter_pkg.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the housekeeping UART transmit arbiter.
// Holds the FSM encoding, the default stall timeout and small helpers
// used by the arbiter datapath.
package uart_tx_arbiter_pkg;

  // Arbiter FSM encoding; the values are visible on debug taps, so keep them fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_t;

  // Four character times at 16 ticks per bit, 10 bits per character.
  localparam int UART_TIMEOUT_TICKS_DEFAULT = 640;

  // Width of the stall counter; supports timeouts up to 1023 ticks.
  localparam int STALL_W = 10;

  // Saturating increment for the forced-release counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Round-robin pick when the arbiter is idle.
  // Exactly one request wins outright; with both requesting, the one
  // that did not own the previous message goes next.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_owner);
    logic pick;
    if (req0 && req1) begin
      pick = ~last_owner;
    end else begin
      pick = req1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter.sv
// Message-granular arbiter sharing one UART transmitter between the
// CPU reply path (requester 0) and the telemetry beacon (requester 1).
// A granted requester keeps the UART until it sends a byte flagged last,
// or until it stalls for TIMEOUT_TICKS baud ticks mid-message.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int TIMEOUT_TICKS = UART_TIMEOUT_TICKS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baudclk16,
  input  logic [7:0] r0_data,
  input  logic       r0_valid,
  input  logic       r0_last,
  output logic       r0_ready,
  input  logic [7:0] r1_data,
  input  logic       r1_valid,
  input  logic       r1_last,
  output logic       r1_ready,
  output logic [7:0] tx_data,
  output logic       tx_write,
  input  logic       tx_ready,
  output logic       busy,
  output logic       owner,
  output logic [7:0] timeouts
);

  // Terminal count: a tick seen while the counter holds this value releases.
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_TICKS - 1);

  arb_state_t         state_q;
  logic [7:0]         tx_data_q;
  logic               tx_write_q;
  logic               r0_ready_q;
  logic               r1_ready_q;
  logic               busy_q;
  logic               owner_q;
  logic [7:0]         timeouts_q;
  logic [STALL_W-1:0] stall_q;
  logic               last_q;

  logic               own_valid;
  logic [7:0]         own_data;
  logic               own_last;
  logic               any_req;
  logic               grant_sel;
  logic               accept;
  logic               stall_tick;
  logic               stall_done;

  // Present the current owner's request lines and the idle-time grant choice.
  always_comb begin
    own_valid  = r0_valid;
    own_data   = r0_data;
    own_last   = r0_last;
    if (owner_q) begin
      own_valid = r1_valid;
      own_data  = r1_data;
      own_last  = r1_last;
    end
    any_req    = r0_valid | r1_valid;
    grant_sel  = rr_pick(r0_valid, r1_valid, owner_q);
    accept     = own_valid & tx_ready;
    stall_tick = ~own_valid & baudclk16;
    stall_done = stall_tick & (stall_q == STALL_LAST);
  end

  // Arbiter FSM with all outputs registered; strobes default low each cycle
  // so tx_write and the ready pulses can never stretch past one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= 8'h00;
      tx_write_q <= 1'b0;
      r0_ready_q <= 1'b0;
      r1_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      owner_q    <= 1'b1;
      timeouts_q <= 8'h00;
      stall_q    <= '0;
      last_q     <= 1'b0;
    end else begin
      tx_write_q <= 1'b0;
      r0_ready_q <= 1'b0;
      r1_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            owner_q <= grant_sel;
            busy_q  <= 1'b1;
            stall_q <= '0;
            state_q <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (accept) begin
            tx_data_q  <= own_data;
            tx_write_q <= 1'b1;
            r0_ready_q <= ~owner_q;
            r1_ready_q <= owner_q;
            stall_q    <= '0;
            last_q     <= own_last;
            state_q    <= ST_HOLD;
          end else if (stall_done) begin
            // Owner went quiet for too long; give the UART back.
            busy_q     <= 1'b0;
            timeouts_q <= sat_inc8(timeouts_q);
            stall_q    <= '0;
            state_q    <= ST_IDLE;
          end else if (stall_tick) begin
            stall_q <= stall_q + 1'b1;
          end
        end
        ST_HOLD: begin
          // One cycle with the strobes high; the UART drops tx_ready meanwhile.
          if (last_q) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_OWN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_write = tx_write_q;
  assign r0_ready = r0_ready_q;
  assign r1_ready = r1_ready_q;
  assign busy     = busy_q;
  assign owner    = owner_q;
  assign timeouts = timeouts_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table for arbitration and
// handshakes, then hand-written sequences for timeout, reset and backpressure.
module tb_uart_tx_arbiter;

  localparam int TO_TICKS   = 8;
  localparam int UART_TICKS = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baudclk16 = 1'b0;
  logic [1:0] rv = 2'b00;
  logic [1:0] rl = 2'b00;
  logic [7:0] rd [2];
  logic       r0_ready, r1_ready;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_ready;
  logic       busy, owner;
  logic [7:0] timeouts;

  logic direct_txr = 1'b1;
  logic txr_drv    = 1'b1;
  logic bp_force   = 1'b0;
  logic uart_busy  = 1'b0;
  int   uart_cnt   = 0;
  logic tick_en    = 1'b0;
  int   tick_div   = 1;
  int   tick_cnt   = 0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       src;
    logic [7:0] data;
  } wr_t;
  wr_t  wlog[$];
  int   rdy_cnt0 = 0;
  int   rdy_cnt1 = 0;
  int   viol = 0;
  logic p_wr = 1'b0, p_r0 = 1'b0, p_r1 = 1'b0;
  logic bad_now;

  uart_tx_arbiter #(.TIMEOUT_TICKS(TO_TICKS)) dut (
    .clk(clk), .reset(reset), .baudclk16(baudclk16),
    .r0_data(rd[0]), .r0_valid(rv[0]), .r0_last(rl[0]), .r0_ready(r0_ready),
    .r1_data(rd[1]), .r1_valid(rv[1]), .r1_last(rl[1]), .r1_ready(r1_ready),
    .tx_data(tx_data), .tx_write(tx_write), .tx_ready(tx_ready),
    .busy(busy), .owner(owner), .timeouts(timeouts)
  );

  always #5 clk = ~clk;

  assign tx_ready = direct_txr ? txr_drv : (!uart_busy && !bp_force);

  // Baud tick source: one-cycle pulse every tick_div cycles when enabled.
  always @(posedge clk) begin
    if (tick_cnt >= tick_div - 1) begin
      tick_cnt  <= 0;
      baudclk16 <= tick_en;
    end else begin
      tick_cnt  <= tick_cnt + 1;
      baudclk16 <= 1'b0;
    end
  end

  // UART model: busy for UART_TICKS baud ticks after each load.
  always @(posedge clk) begin
    if (reset) begin
      uart_busy <= 1'b0;
      uart_cnt  <= 0;
    end else if (tx_write) begin
      uart_busy <= 1'b1;
      uart_cnt  <= UART_TICKS;
    end else if (uart_busy && baudclk16) begin
      if (uart_cnt <= 1) uart_busy <= 1'b0;
      uart_cnt <= uart_cnt - 1;
    end
  end

  // Protocol monitor: log writes, count ready pulses, flag illegal strobes.
  assign bad_now = (tx_write && p_wr) || (r0_ready && p_r0) || (r1_ready && p_r1) ||
                   (r0_ready && owner) || (r1_ready && !owner) ||
                   ((r0_ready || r1_ready) != tx_write);
  always @(negedge clk) begin
    if (tx_write) wlog.push_back({owner, tx_data});
    if (r0_ready) rdy_cnt0 <= rdy_cnt0 + 1;
    if (r1_ready) rdy_cnt1 <= rdy_cnt1 + 1;
    if (bad_now) viol <= viol + 1;
    p_wr <= tx_write;
    p_r0 <= r0_ready;
    p_r1 <= r1_ready;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_rdy(input int who, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if ((who == 0) ? r0_ready : r1_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input int who, input int n, input logic [7:0] base, input logic end_last);
    bit ok;
    for (int i = 0; i < n; i++) begin
      rd[who] = base + 8'(i);
      rl[who] = end_last && (i == n - 1);
      rv[who] = 1'b1;
      wait_rdy(who, 3000, ok);
      @(posedge clk); #1;
      check($sformatf("rdy_wait_r%0d", who), int'(ok), 1);
      if (!ok) break;
    end
    rv[who] = 1'b0;
    rl[who] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    rv = 2'b00;
    rl = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_timeout(output bit released);
    released = 1'b0;
    @(posedge clk); #1;
    rv[1] = 1'b1;
    rl[1] = 1'b0;
    @(posedge clk); #1;
    rv[1] = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) begin
        released = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_write"}, int'(tx_write), 0);
    check({tag, "_tx_data"}, int'(tx_data), 0);
    check({tag, "_r0_ready"}, int'(r0_ready), 0);
    check({tag, "_r1_ready"}, int'(r1_ready), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_owner"}, int'(owner), 1);
    check({tag, "_timeouts"}, int'(timeouts), 0);
  endtask

  typedef struct packed {
    logic       r0v;
    logic [7:0] r0d;
    logic       r0l;
    logic       r1v;
    logic [7:0] r1d;
    logic       r1l;
    logic       txr;
    logic       e_wr;
    logic [7:0] e_data;
    logic       e_r0r;
    logic       e_r1r;
    logic       e_busy;
    logic       e_own;
  } vec_t;

  vec_t vecs [13];
  int   base, r0b, r1b, ticks, nrel;
  bit   ok, rel, prev_tick;
  int   exp_data [5];
  int   exp_src  [5];

  initial begin
    rd[0] = 8'h00;
    rd[1] = 8'h00;
    //            r0v  r0d    r0l  r1v  r1d    r1l  txr   wr   data   r0r  r1r  busy own
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 8'h41, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 8'h41, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 8'h41, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'h42, 1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 8'h42, 1'b1, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b1, 8'h42, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state, sampled while reset is still asserted.
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;

    // Cycle table: drive row, let one edge pass, compare just after it.
    for (int i = 0; i < 13; i++) begin
      rv[0] = vecs[i].r0v; rd[0] = vecs[i].r0d; rl[0] = vecs[i].r0l;
      rv[1] = vecs[i].r1v; rd[1] = vecs[i].r1d; rl[1] = vecs[i].r1l;
      txr_drv = vecs[i].txr;
      @(posedge clk); #1;
      check($sformatf("vec%0d_tx_write", i), int'(tx_write), int'(vecs[i].e_wr));
      check($sformatf("vec%0d_tx_data", i), int'(tx_data), int'(vecs[i].e_data));
      check($sformatf("vec%0d_r0_ready", i), int'(r0_ready), int'(vecs[i].e_r0r));
      check($sformatf("vec%0d_r1_ready", i), int'(r1_ready), int'(vecs[i].e_r1r));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
      check($sformatf("vec%0d_owner", i), int'(owner), int'(vecs[i].e_own));
    end
    check("vec_timeouts", int'(timeouts), 0);

    // Single message through the UART model.
    do_reset();
    direct_txr = 1'b0;
    tick_div = 2;
    tick_en = 1'b1;
    base = wlog.size();
    r0b = rdy_cnt0;
    send(0, 3, 8'h41, 1'b1);
    @(negedge clk);
    check("single_nwrites", wlog.size() - base, 3);
    for (int i = 0; i < 3; i++) begin
      if (base + i < wlog.size()) begin
        check($sformatf("single_data%0d", i), int'(wlog[base+i].data), 8'h41 + i);
        check($sformatf("single_src%0d", i), int'(wlog[base+i].src), 0);
      end
    end
    check("single_r0_readies", rdy_cnt0 - r0b, 3);
    check("single_busy_end", int'(busy), 0);
    check("single_owner_end", int'(owner), 0);

    // Contention right after reset: r0 first, whole messages, no interleave.
    do_reset();
    base = wlog.size();
    r0b = rdy_cnt0;
    r1b = rdy_cnt1;
    fork
      send(0, 3, 8'h41, 1'b1);
      send(1, 2, 8'hA1, 1'b1);
    join
    exp_data = '{8'h41, 8'h42, 8'h43, 8'hA1, 8'hA2};
    exp_src  = '{0, 0, 0, 1, 1};
    check("cont_nwrites", wlog.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < wlog.size()) begin
        check($sformatf("cont_data%0d", i), int'(wlog[base+i].data), exp_data[i]);
        check($sformatf("cont_src%0d", i), int'(wlog[base+i].src), exp_src[i]);
      end
    end
    check("cont_r0_readies", rdy_cnt0 - r0b, 3);
    check("cont_r1_readies", rdy_cnt1 - r1b, 2);

    // Round-robin with one-byte messages from both sides.
    base = wlog.size();
    fork
      begin
        for (int k = 0; k < 4; k++) send(0, 1, 8'h10 + 8'(k), 1'b1);
      end
      begin
        for (int k = 0; k < 4; k++) send(1, 1, 8'h20 + 8'(k), 1'b1);
      end
    join
    check("rr_nwrites", wlog.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < wlog.size()) begin
        check($sformatf("rr_src%0d", i), int'(wlog[base+i].src), i % 2);
      end
    end

    // Timeout: r1 stalls after a non-last byte.
    do_reset();
    tick_div = 3;
    base = wlog.size();
    send(1, 1, 8'hB1, 1'b0);
    rd[0] = 8'h77;
    rl[0] = 1'b1;
    rv[0] = 1'b1;
    ticks = 0;
    prev_tick = 1'b0;
    rel = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!busy) begin
        rel = 1'b1;
        break;
      end
      if (baudclk16) ticks++;
      prev_tick = baudclk16;
    end
    check("to_released", int'(rel), 1);
    check("to_tick_count", ticks, TO_TICKS);
    check("to_after_tick", int'(prev_tick), 1);
    check("to_timeouts", int'(timeouts), 1);
    @(negedge clk);
    check("to_r0_grant_owner", int'(owner), 0);
    check("to_r0_grant_busy", int'(busy), 1);
    wait_rdy(0, 3000, ok);
    @(posedge clk); #1;
    rv[0] = 1'b0;
    rl[0] = 1'b0;
    check("to_r0_ready", int'(ok), 1);
    check("to_nwrites", wlog.size() - base, 2);
    if (wlog.size() - base == 2) begin
      check("to_data0", int'(wlog[base].data), 8'hB1);
      check("to_data1", int'(wlog[base+1].data), 8'h77);
      check("to_src1", int'(wlog[base+1].src), 0);
    end

    // Saturation of the timeout counter.
    tick_div = 1;
    nrel = 0;
    for (int k = 0; k < 254; k++) begin
      pulse_timeout(rel);
      if (rel) nrel++;
    end
    check("sat_releases", nrel, 254);
    check("sat_at_255", int'(timeouts), 255);
    pulse_timeout(rel);
    check("sat_extra_release", int'(rel), 1);
    check("sat_stays_255", int'(timeouts), 255);

    // Reset during HOLD of byte 2 of a 4-byte message.
    do_reset();
    tick_div = 2;
    base = wlog.size();
    rd[0] = 8'h11;
    rl[0] = 1'b0;
    rv[0] = 1'b1;
    wait_rdy(0, 3000, ok);
    @(posedge clk); #1;
    rd[0] = 8'h12;
    wait_rdy(0, 3000, ok);
    check("rmid_byte2_ready", int'(ok), 1);
    reset = 1'b1;
    rv[0] = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("rmid");
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("rmid_no_more_writes", wlog.size() - base, 2);
    check("rmid_busy_idle", int'(busy), 0);

    // Backpressure: owner valid, UART not ready for 100 cycles, ticks running.
    do_reset();
    tick_div = 1;
    bp_force = 1'b1;
    base = wlog.size();
    rd[1] = 8'hC3;
    rl[1] = 1'b1;
    rv[1] = 1'b1;
    nrel = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c > 0 && !busy) nrel++;
    end
    check("bp_no_writes", wlog.size() - base, 0);
    check("bp_busy_held", nrel, 0);
    check("bp_no_timeout", int'(timeouts), 0);
    check("bp_owner", int'(owner), 1);
    @(posedge clk); #1;
    bp_force = 1'b0;
    wait_rdy(1, 50, ok);
    @(posedge clk); #1;
    rv[1] = 1'b0;
    rl[1] = 1'b0;
    check("bp_release_ready", int'(ok), 1);
    check("bp_release_write", wlog.size() - base, 1);
    if (wlog.size() - base == 1) check("bp_data", int'(wlog[base].data), 8'hC3);

    repeat (2) @(negedge clk);
    check("strobe_protocol_violations", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
